// File: rtl/sram_target_if.sv
// Multiplexed address/data bus between a bus master and the SRAM target.
// The master drives address/data, address latch enables and the strobes;
// the target returns read data, its drive enable, decode hit and error flag.
interface sram_target_if;
   logic [15:0] bus_in;
   logic [15:0] bus_out;
   logic        bus_oe;
   logic        ale0;
   logic        ale1;
   logic        oe_n;
   logic        we_n;
   logic        bhe_n;
   logic        hit;
   logic        err;

   modport master (
      output bus_in,
      output ale0,
      output ale1,
      output oe_n,
      output we_n,
      output bhe_n,
      input  bus_out,
      input  bus_oe,
      input  hit,
      input  err
   );

   modport slave (
      input  bus_in,
      input  ale0,
      input  ale1,
      input  oe_n,
      input  we_n,
      input  bhe_n,
      output bus_out,
      output bus_oe,
      output hit,
      output err
   );
endinterface

// File: rtl/sram_target.sv
// SRAM target on a multiplexed 16-bit address/data bus.
// A 32-bit address is latched in two halves by ale0/ale1; the decoded
// halfword array is read with a one-cycle latency and written with byte
// lanes committed when the write strobe is released. Strobe conflicts and
// address latching in the middle of an access are trapped in a sticky error.
module sram_target #(
   parameter int          AW   = 12,
   parameter logic [31:0] BASE = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset_n,
   sram_target_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   // Decode: only the bits above the halfword index and byte offset matter.
   function automatic logic addr_match(input logic [31:0] a);
      return (a[31:AW+1] == BASE[31:AW+1]);
   endfunction

   // Halfword array; deliberately carries no reset.
   logic [15:0] mem_q [0:(2**AW)-1];

   state_t      state_q,   state_d;
   logic [31:0] addr_q,    addr_d;
   logic        hit_q,     hit_d;
   logic        bus_oe_q,  bus_oe_d;
   logic [15:0] bus_out_q, bus_out_d;
   logic        err_q,     err_d;
   logic [15:0] cap_q,     cap_d;

   logic [AW-1:0] idx_s;
   logic [15:0]   rd_data_s;
   logic          lane_lo_s;
   logic          lane_hi_s;
   logic          ale_any_s;
   logic          conflict_s;
   logic          wr_lo_s;
   logic          wr_hi_s;

   assign idx_s      = addr_q[AW:1];
   assign rd_data_s  = mem_q[idx_s];
   assign lane_lo_s  = ~addr_q[0];
   assign lane_hi_s  = ~bus.bhe_n;
   assign ale_any_s  = bus.ale0 | bus.ale1;
   assign conflict_s = ~bus.oe_n & ~bus.we_n;

   // Next-state, address latch, capture and output-register computation.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      hit_d     = addr_match(addr_q);
      bus_oe_d  = bus_oe_q;
      bus_out_d = bus_out_q;
      err_d     = err_q;
      cap_d     = cap_q;
      wr_lo_s   = 1'b0;
      wr_hi_s   = 1'b0;

      if (bus.ale0) begin
         addr_d[15:0] = bus.bus_in;
      end else begin
         addr_d[15:0] = addr_q[15:0];
      end
      if (bus.ale1) begin
         addr_d[31:16] = bus.bus_in;
      end else begin
         addr_d[31:16] = addr_q[31:16];
      end

      case (state_q)
         ST_IDLE: begin
            bus_oe_d = 1'b0;
            if (conflict_s) begin
               state_d = ST_ERROR;
               err_d   = 1'b1;
            end else if (!bus.oe_n && hit_q && !ale_any_s) begin
               // Read data is registered here so it is valid one cycle later.
               state_d   = ST_READ;
               bus_oe_d  = 1'b1;
               bus_out_d = rd_data_s;
            end else if (!bus.we_n && hit_q && !ale_any_s) begin
               state_d = ST_WRITE;
               cap_d   = bus.bus_in;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (conflict_s || (!bus.oe_n && ale_any_s)) begin
               state_d  = ST_ERROR;
               bus_oe_d = 1'b0;
               err_d    = 1'b1;
            end else if (bus.oe_n) begin
               // Strobe released: the access is over, so an ALE in this
               // same cycle is the next address phase, not a violation.
               state_d  = ST_IDLE;
               bus_oe_d = 1'b0;
            end else begin
               bus_oe_d  = 1'b1;
               bus_out_d = rd_data_s;
            end
         end
         ST_WRITE: begin
            if (conflict_s || (!bus.we_n && ale_any_s)) begin
               state_d  = ST_ERROR;
               bus_oe_d = 1'b0;
               err_d    = 1'b1;
               cap_d    = 16'h0000;
            end else if (bus.we_n) begin
               // Lanes are evaluated at commit time, not at write entry.
               state_d = ST_IDLE;
               wr_lo_s = lane_lo_s & reset_n;
               wr_hi_s = lane_hi_s & reset_n;
            end else begin
               cap_d = bus.bus_in;
            end
         end
         ST_ERROR: begin
            bus_oe_d = 1'b0;
            if (bus.oe_n && bus.we_n) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ERROR;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            bus_oe_d = 1'b0;
         end
      endcase
   end

   // Control/data registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= 32'h0000_0000;
         hit_q     <= 1'b0;
         bus_oe_q  <= 1'b0;
         bus_out_q <= 16'h0000;
         err_q     <= 1'b0;
         cap_q     <= 16'h0000;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         hit_q     <= hit_d;
         bus_oe_q  <= bus_oe_d;
         bus_out_q <= bus_out_d;
         err_q     <= err_d;
         cap_q     <= cap_d;
      end
   end

   // Byte-lane commit of the captured write data into the array.
   always_ff @(posedge clk) begin
      if (wr_lo_s) begin
         mem_q[idx_s][7:0] <= cap_q[7:0];
      end
      if (wr_hi_s) begin
         mem_q[idx_s][15:8] <= cap_q[15:8];
      end
   end

   // The drive enable is cut immediately on strobe release, write strobe or
   // any address phase so the target never fights the master on the bus.
   assign bus.bus_oe  = bus_oe_q & ~bus.oe_n & bus.we_n & ~bus.ale0 & ~bus.ale1;
   assign bus.bus_out = bus_out_q;
   assign bus.hit     = hit_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_sram_target.sv
// Directed bench for sram_target: every test task drives the bus and checks
// the observed outputs against hand-computed values.
module tb_sram_target;
   logic clk;
   logic reset_n;
   int   checks;
   int   passes;

   sram_target_if bus_if ();

   sram_target #(.AW(12), .BASE(32'h0000_0000)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 2-3 ns after the edge.
   task automatic clk_step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_addr(input logic [31:0] a);
      bus_if.ale0 = 1'b1; bus_if.bus_in = a[15:0];
      clk_step();
      bus_if.ale0 = 1'b0; bus_if.ale1 = 1'b1; bus_if.bus_in = a[31:16];
      clk_step();
      bus_if.ale1 = 1'b0; bus_if.bus_in = 16'h0000;
      clk_step();
   endtask

   task automatic do_write(input logic [15:0] d, input logic bhe);
      bus_if.we_n = 1'b0; bus_if.bus_in = d; bus_if.bhe_n = bhe;
      clk_step();
      clk_step();
      bus_if.we_n = 1'b1;
      clk_step();
      bus_if.bhe_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus_if.bus_in = 16'h0000; bus_if.ale0 = 1'b0; bus_if.ale1 = 1'b0;
      bus_if.oe_n = 1'b1; bus_if.we_n = 1'b1; bus_if.bhe_n = 1'b1;
      clk_step();
      clk_step();
      #1;
      checks++; if (bus_if.bus_oe !== 1'b0) $display("FAIL rst_oe got %b exp 0", bus_if.bus_oe); else passes++;
      checks++; if (bus_if.bus_out !== 16'h0000) $display("FAIL rst_out got %h exp 0000", bus_if.bus_out); else passes++;
      checks++; if (bus_if.hit !== 1'b0) $display("FAIL rst_hit got %b exp 0", bus_if.hit); else passes++;
      checks++; if (bus_if.err !== 1'b0) $display("FAIL rst_err got %b exp 0", bus_if.err); else passes++;
      reset_n = 1'b1;
      clk_step();
   endtask

   task automatic test_write_read();
      set_addr(32'h0000_0010);
      #1;
      checks++; if (bus_if.hit !== 1'b1) $display("FAIL wr_hit got %b exp 1", bus_if.hit); else passes++;
      bus_if.we_n = 1'b0; bus_if.bus_in = 16'hBEEF; bus_if.bhe_n = 1'b0;
      #1;
      checks++; if (bus_if.bus_oe !== 1'b0) $display("FAIL wr_oe got %b exp 0", bus_if.bus_oe); else passes++;
      clk_step();
      clk_step();
      bus_if.we_n = 1'b1;
      clk_step();
      bus_if.bhe_n = 1'b1;
      bus_if.oe_n = 1'b0;
      #1;
      checks++; if (bus_if.bus_oe !== 1'b0) $display("FAIL rd_lat got %b exp 0", bus_if.bus_oe); else passes++;
      clk_step();
      #1;
      checks++; if (bus_if.bus_oe !== 1'b1) $display("FAIL rd_oe got %b exp 1", bus_if.bus_oe); else passes++;
      checks++; if (bus_if.bus_out !== 16'hBEEF) $display("FAIL rd_beef got %h exp beef", bus_if.bus_out); else passes++;
      bus_if.oe_n = 1'b1;
      #1;
      checks++; if (bus_if.bus_oe !== 1'b0) $display("FAIL rd_release got %b exp 0", bus_if.bus_oe); else passes++;
      clk_step();
   endtask

   task automatic test_byte_lanes();
      set_addr(32'h0000_0011);
      do_write(16'h12AB, 1'b0);
      set_addr(32'h0000_0010);
      bus_if.oe_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.bus_out !== 16'h12EF) $display("FAIL lane_hi got %h exp 12ef", bus_if.bus_out); else passes++;
      bus_if.oe_n = 1'b1;
      clk_step();
      do_write(16'h0034, 1'b1);
      bus_if.oe_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.bus_out !== 16'h1234) $display("FAIL lane_lo got %h exp 1234", bus_if.bus_out); else passes++;
      bus_if.oe_n = 1'b1;
      clk_step();
      // Odd address with bhe_n high: no lane enabled, nothing changes.
      set_addr(32'h0000_0011);
      do_write(16'hFFFF, 1'b1);
      set_addr(32'h0000_0010);
      bus_if.oe_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.bus_out !== 16'h1234) $display("FAIL lane_none got %h exp 1234", bus_if.bus_out); else passes++;
      bus_if.oe_n = 1'b1;
      clk_step();
   endtask

   task automatic test_miss();
      set_addr(32'h0001_0010);
      #1;
      checks++; if (bus_if.hit !== 1'b0) $display("FAIL miss_hit got %b exp 0", bus_if.hit); else passes++;
      bus_if.oe_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.bus_oe !== 1'b0) $display("FAIL miss_oe1 got %b exp 0", bus_if.bus_oe); else passes++;
      clk_step();
      #1;
      checks++; if (bus_if.bus_oe !== 1'b0) $display("FAIL miss_oe2 got %b exp 0", bus_if.bus_oe); else passes++;
      bus_if.oe_n = 1'b1;
      clk_step();
      do_write(16'hDEAD, 1'b0);
      set_addr(32'h0000_0010);
      bus_if.oe_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.bus_out !== 16'h1234) $display("FAIL miss_nowr got %h exp 1234", bus_if.bus_out); else passes++;
      bus_if.oe_n = 1'b1;
      clk_step();
   endtask

   task automatic test_error();
      bus_if.oe_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.bus_oe !== 1'b1) $display("FAIL err_pre_oe got %b exp 1", bus_if.bus_oe); else passes++;
      bus_if.we_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.err !== 1'b1) $display("FAIL err_set got %b exp 1", bus_if.err); else passes++;
      bus_if.oe_n = 1'b1; bus_if.we_n = 1'b1;
      #1;
      checks++; if (bus_if.bus_oe !== 1'b0) $display("FAIL err_oe got %b exp 0", bus_if.bus_oe); else passes++;
      clk_step();
      clk_step();
      #1;
      checks++; if (bus_if.err !== 1'b1) $display("FAIL err_sticky got %b exp 1", bus_if.err); else passes++;
      // ALE while a read is in progress also traps.
      bus_if.oe_n = 1'b0;
      clk_step();
      bus_if.ale0 = 1'b1; bus_if.bus_in = 16'h0010;
      #1;
      checks++; if (bus_if.bus_oe !== 1'b0) $display("FAIL ale_oe got %b exp 0", bus_if.bus_oe); else passes++;
      clk_step();
      bus_if.ale0 = 1'b0; bus_if.oe_n = 1'b1; bus_if.bus_in = 16'h0000;
      clk_step();
      reset_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.err !== 1'b0) $display("FAIL err_clear got %b exp 0", bus_if.err); else passes++;
      reset_n = 1'b1;
      clk_step();
   endtask

   task automatic test_reset_write();
      set_addr(32'h0000_0006);
      do_write(16'h5555, 1'b0);
      bus_if.oe_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.bus_out !== 16'h5555) $display("FAIL rw_prior got %h exp 5555", bus_if.bus_out); else passes++;
      bus_if.oe_n = 1'b1;
      clk_step();
      bus_if.we_n = 1'b0; bus_if.bus_in = 16'hAAAA; bus_if.bhe_n = 1'b0;
      clk_step();
      clk_step();
      reset_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.bus_out !== 16'h0000) $display("FAIL rw_out got %h exp 0000", bus_if.bus_out); else passes++;
      checks++; if (bus_if.hit !== 1'b0) $display("FAIL rw_hit got %b exp 0", bus_if.hit); else passes++;
      checks++; if (bus_if.err !== 1'b0) $display("FAIL rw_err got %b exp 0", bus_if.err); else passes++;
      bus_if.we_n = 1'b1; bus_if.bhe_n = 1'b1;
      clk_step();
      reset_n = 1'b1;
      clk_step();
      set_addr(32'h0000_0006);
      bus_if.oe_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.bus_out !== 16'h5555) $display("FAIL rw_kept got %h exp 5555", bus_if.bus_out); else passes++;
      bus_if.oe_n = 1'b1;
      clk_step();
   endtask

   task automatic test_back_to_back();
      set_addr(32'h0000_0002);
      do_write(16'hA1B2, 1'b0);
      set_addr(32'h0000_0004);
      do_write(16'hC3D4, 1'b0);
      set_addr(32'h0000_0002);
      bus_if.oe_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.bus_oe !== 1'b1) $display("FAIL b2b_oe1 got %b exp 1", bus_if.bus_oe); else passes++;
      checks++; if (bus_if.bus_out !== 16'hA1B2) $display("FAIL b2b_d1 got %h exp a1b2", bus_if.bus_out); else passes++;
      // Gap cycle: strobe released, next address latched.
      bus_if.oe_n = 1'b1; bus_if.ale0 = 1'b1; bus_if.bus_in = 16'h0004;
      #1;
      checks++; if (bus_if.bus_oe !== 1'b0) $display("FAIL b2b_gap got %b exp 0", bus_if.bus_oe); else passes++;
      clk_step();
      bus_if.ale0 = 1'b0; bus_if.bus_in = 16'h0000; bus_if.oe_n = 1'b0;
      clk_step();
      #1;
      checks++; if (bus_if.bus_oe !== 1'b1) $display("FAIL b2b_oe2 got %b exp 1", bus_if.bus_oe); else passes++;
      checks++; if (bus_if.bus_out !== 16'hC3D4) $display("FAIL b2b_d2 got %h exp c3d4", bus_if.bus_out); else passes++;
      checks++; if (bus_if.err !== 1'b0) $display("FAIL b2b_err got %b exp 0", bus_if.err); else passes++;
      bus_if.oe_n = 1'b1;
      clk_step();
   endtask

   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_miss();
      test_error();
      test_reset_write();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
